// File: rtl/sccpu_uart_tx_if.sv
// Data-memory bus between the single-cycle CPU and a memory-mapped peripheral.
// The CPU (master) drives the ALU address, store data and write enable; the
// peripheral (slave) returns its window-claim flag and load data.
interface sccpu_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output we,
        input  sel,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output sel,
        output rdata
    );
endinterface

// File: rtl/sccpu_uart_tx.sv
// Memory-mapped UART transmitter for the single-cycle CPU data-memory port.
// Registers: TXDATA (+0x0, push), STATUS (+0x4), DIV (+0x8). Bytes are queued
// in a circular FIFO and sent LSB first at div clocks per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit (8E1) and
// sets STATUS bit 8; when undefined the frame is 8N1.
module sccpu_uart_tx #(
    parameter logic [31:0] BASE       = 32'h0000_FF00,
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic           clock,
    input  logic           reset,
    sccpu_uart_tx_if.slave bus,
    output logic           txd,
    output logic           irq
);
    localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [1:0]          OFF_TXDATA = 2'd0;
    localparam logic [1:0]          OFF_STATUS = 2'd1;
    localparam logic [1:0]          OFF_DIV    = 2'd2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // A divisor of zero would never end a bit period, so it is stored as 1.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovf;
    logic [15:0]           div;
    logic [15:0]           baud_cnt;
    logic [15:0]           baud_cnt_nxt;
    state_t                state;
    state_t                state_nxt;
    logic [7:0]            shift;
    logic [7:0]            shift_nxt;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_idx_nxt;
`ifdef UART_TX_PARITY_EN
    logic [7:0]            tx_byte;
`endif

    logic        sel;
    logic [31:0] rdata;
    logic [31:0] status;
    logic        fifo_full;
    logic        fifo_empty;
    logic        wr_acc;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        div_wr;
    logic        ovf_clr;
    logic        unused_bits;

    assign sel         = (bus.addr[31:4] == BASE[31:4]) && (bus.addr[3:2] != 2'b11);
    assign bus.sel     = sel;
    assign bus.rdata   = rdata;
    assign unused_bits = ^{bus.wdata[31:16], bus.addr[1:0]};

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign wr_acc     = bus.we & sel;
    assign push_req   = wr_acc && (bus.addr[3:2] == OFF_TXDATA);
    assign push       = push_req && !fifo_full;
    assign div_wr     = wr_acc && (bus.addr[3:2] == OFF_DIV);
    assign ovf_clr    = wr_acc && (bus.addr[3:2] == OFF_STATUS) && bus.wdata[3];

    // Assemble STATUS from the registered FIFO/FSM state.
    always_comb begin
        status      = '0;
        status[0]   = fifo_full;
        status[1]   = fifo_empty;
        status[2]   = (state != S_IDLE);
        status[3]   = ovf;
        status[7:4] = 4'(count);
`ifdef UART_TX_PARITY_EN
        status[8]   = 1'b1;
`endif
    end

    // Load data mux; loads see state from before this cycle's edge.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (bus.addr[3:2])
                OFF_STATUS: rdata = status;
                OFF_DIV:    rdata = {16'b0, div};
                default:    rdata = '0;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && fifo_full) ovf <= 1'b1;
            else if (ovf_clr)          ovf <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.wdata[7:0];
    end

    // Baud divisor register; a new value is picked up at the next bit reload.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      div <= DIV_RESET;
        else if (div_wr) div <= clamp_div(bus.wdata[15:0]);
    end

    // Transmit FSM next state, baud counter, bit counter and FIFO pop.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        shift_nxt    = shift;
        bit_idx_nxt  = bit_idx;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_nxt    = mem[rd_ptr];
                    bit_idx_nxt  = 3'd0;
                    baud_cnt_nxt = div - 16'd1;
                    state_nxt    = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_nxt = div - 16'd1;
                    state_nxt    = S_DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_nxt = div - 16'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_nxt = div - 16'd1;
                    state_nxt    = S_STOP;
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_cnt == 16'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transmit FSM control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
        end
    end

    // Transmit data shift register (and parity source byte).
    always_ff @(posedge clock) begin
        shift <= shift_nxt;
`ifdef UART_TX_PARITY_EN
        if (pop) tx_byte <= mem[rd_ptr];
`endif
    end

    // Serial line follows the FSM state, so reset forces it high at once.
    always_comb begin
        case (state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd = ^tx_byte;
`endif
            default:  txd = 1'b1;
        endcase
    end

    // Interrupt when nothing is queued and the line is idle, one cycle late.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) irq <= 1'b1;
        else        irq <= (state == S_IDLE) && fifo_empty;
    end
endmodule

// File: tb/tb_sccpu_uart_tx.sv
// Self-checking bench for sccpu_uart_tx: register-access vector table, exact
// frame waveforms, FIFO fill/overflow/wrap, push-with-pop, divisor corners and
// reset in the middle of a frame.
module tb_sccpu_uart_tx;
    localparam logic [31:0] A_TX  = 32'h0000_FF00;
    localparam logic [31:0] A_ST  = 32'h0000_FF04;
    localparam logic [31:0] A_DIV = 32'h0000_FF08;
`ifdef UART_TX_PARITY_EN
    localparam int          PAR_EN = 1;
    localparam logic [31:0] PBIT   = 32'h0000_0100;
`else
    localparam int          PAR_EN = 0;
    localparam logic [31:0] PBIT   = 32'h0000_0000;
`endif
    localparam logic [31:0] ST_EMPTY = 32'h2 | PBIT;
    localparam int          NV       = 19;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clock;
    logic reset;
    logic txd;
    logic irq;
    int   checks;
    int   errors;
    int   rx_div;
    logic rx_en;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    vec_t vecs[NV];

    sccpu_uart_tx_if bus();

    sccpu_uart_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .txd   (txd),
        .irq   (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clock);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        repeat (2) @(negedge clock);
        while (irq !== 1'b1 && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(irq), 32'h1);
    endtask

    task automatic check_rx(input string name);
        check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    // Expected line level k samples after the push edge; the first n_first
    // segments (start, data bits, ...) last d_first clocks, the rest d_rest.
    function automatic logic frame_txd(input int k, input logic [7:0] b,
                                       input int d_first, input int n_first, input int d_rest);
        int pos;
        int len;
        if (k == 0) return 1'b1;
        pos = 1;
        for (int j = 0; j < 10 + PAR_EN; j++) begin
            len = (j < n_first) ? d_first : d_rest;
            if (k < pos + len) begin
                if (j == 0) return 1'b0;
                if (j <= 8) return b[j-1];
                if (PAR_EN == 1 && j == 9) return ^b;
                return 1'b1;
            end
            pos += len;
        end
        return 1'b1;
    endfunction

    // Background receiver: decodes frames at rx_div clocks per bit.
    initial begin : rx_proc
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (rx_en && reset && txd === 1'b0) begin
                b = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (rx_div) @(negedge clock);
                    b[i] = txd;
                end
                if (PAR_EN == 1) begin
                    repeat (rx_div) @(negedge clock);
                    check("rx_parity", 32'(txd), 32'(^b));
                end
                repeat (rx_div) @(negedge clock);
                check("rx_stop", 32'(txd), 32'h1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : main
        logic [31:0] rd;
        int n;
        int kmax;
        checks = 0;
        errors = 0;
        rx_en  = 1'b0;
        rx_div = 4;
        reset  = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;

        vecs[0]  = '{1'b0, A_DIV,         32'h0,         1'b1, 32'h1B2};
        vecs[1]  = '{1'b0, A_ST,          32'h0,         1'b1, ST_EMPTY};
        vecs[2]  = '{1'b0, A_TX,          32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_FF0C, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_FF10, 32'h0,         1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_FE08, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{1'b1, A_DIV,         32'h0,         1'b1, 32'h1B2};
        vecs[7]  = '{1'b0, A_DIV,         32'h0,         1'b1, 32'h1};
        vecs[8]  = '{1'b0, 32'h0000_FF0B, 32'h0,         1'b1, 32'h1};
        vecs[9]  = '{1'b1, 32'h0000_FF0A, 32'h0001_2345, 1'b1, 32'h1};
        vecs[10] = '{1'b0, A_DIV,         32'h0,         1'b1, 32'h2345};
        vecs[11] = '{1'b1, A_ST,          32'hFFFF_FFFF, 1'b1, ST_EMPTY};
        vecs[12] = '{1'b0, A_ST,          32'h0,         1'b1, ST_EMPTY};
        vecs[13] = '{1'b1, 32'h0000_FF0C, 32'h41,        1'b0, 32'h0};
        vecs[14] = '{1'b0, A_ST,          32'h0,         1'b1, ST_EMPTY};
        vecs[15] = '{1'b1, 32'h0000_FE00, 32'h41,        1'b0, 32'h0};
        vecs[16] = '{1'b0, A_ST,          32'h0,         1'b1, ST_EMPTY};
        vecs[17] = '{1'b1, A_DIV,         32'h4,         1'b1, 32'h2345};
        vecs[18] = '{1'b0, A_DIV,         32'h0,         1'b1, 32'h4};

        // Reset state while reset is held.
        #12;
        check("rst_txd", 32'(txd), 32'h1);
        check("rst_irq", 32'(irq), 32'h1);
        bus_read(A_ST, rd);
        check("rst_status", rd, ST_EMPTY);
        bus_read(A_DIV, rd);
        check("rst_div", rd, 32'h1B2);
        @(negedge clock);
        reset = 1'b1;

        // Register decode and access table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            bus.we    = vecs[i].we;
            #1;
            check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_txd", i), 32'(txd), 32'h1);
            @(posedge clock);
            #1;
            bus.we = 1'b0;
        end

        // Single frame 0x55 at div=4, sampled every cycle.
        bus_write(A_TX, 32'h55);
        kmax = 1 + (10 + PAR_EN) * 4 + 1;
        for (int k = 0; k < kmax; k++) begin
            @(negedge clock);
            check($sformatf("frame55_k%0d", k), 32'(txd), 32'(frame_txd(k, 8'h55, 4, 99, 4)));
            if (k == 2 || k == kmax - 1) check($sformatf("frame55_irq_k%0d", k), 32'(irq), 32'h0);
        end
        @(negedge clock);
        check("frame55_irq_after", 32'(irq), 32'h1);

        // Divisor 4 -> 8 written during data bit 0: bit 0 keeps 4 clocks.
        bus_write(A_TX, 32'hA5);
        kmax = 1 + 2 * 4 + (8 + PAR_EN) * 8 + 1;
        for (int k = 0; k < kmax; k++) begin
            @(negedge clock);
            check($sformatf("divchg_k%0d", k), 32'(txd), 32'(frame_txd(k, 8'hA5, 4, 2, 8)));
            if (k == 5) begin
                bus.addr  = A_DIV;
                bus.wdata = 32'h8;
                bus.we    = 1'b1;
            end else begin
                bus.we = 1'b0;
            end
        end
        wait_idle("divchg_idle", 50);
        bus_read(A_DIV, rd);
        check("divchg_div", rd, 32'h8);

        // DIV=0 is stored as 1: one clock per bit.
        bus_write(A_DIV, 32'h0);
        bus_read(A_DIV, rd);
        check("div0_read", rd, 32'h1);
        rx_div = 1;
        rx_en  = 1'b1;
        rx_q.delete();
        exp_q = '{8'h96, 8'h69};
        bus_write(A_TX, 32'h96);
        bus_write(A_TX, 32'h69);
        wait_idle("div1_idle", 100);
        check_rx("div1_rx");

        // Queue fill, overflow, ovf clear, pointer wrap and ordering.
        bus_write(A_DIV, 32'h4);
        rx_div = 4;
        rx_q.delete();
        exp_q = '{8'hA0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h10, 8'h11, 8'h12, 8'h13};
        bus_write(A_TX, 32'hA0);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 8; i++) bus_write(A_TX, 32'(i));
        bus_read(A_ST, rd);
        check("q_full", rd, 32'h85 | PBIT);
        bus_write(A_TX, 32'h08);
        bus_read(A_ST, rd);
        check("q_ovf_set", rd, 32'h8D | PBIT);
        bus_write(A_ST, 32'h0);
        bus_read(A_ST, rd);
        check("q_ovf_w0", rd, 32'h8D | PBIT);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd);
        check("q_ovf_clr", rd, 32'h85 | PBIT);
        n = 0;
        rd = '0;
        while (n < 800) begin
            @(negedge clock);
            bus_read(A_ST, rd);
            if (rd[7:4] == 4'd4) break;
            n++;
        end
        check("q_count4", 32'(rd[7:4]), 32'h4);
        for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h10 + 32'(i));
        bus_read(A_ST, rd);
        check("q_refill", rd, 32'h85 | PBIT);
        wait_idle("q_idle", 1500);
        check_rx("q_rx");

        // Push in the exact IDLE cycle that pops, with three bytes queued.
        bus_write(A_DIV, 32'h2);
        rx_div = 2;
        rx_q.delete();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        bus_write(A_TX, 32'h44);
        bus_read(A_ST, rd);
        check("sim_pre", rd, 32'h34 | PBIT);
        n = 0;
        rd = 32'h4;
        while (n < 100) begin
            @(negedge clock);
            bus_read(A_ST, rd);
            if (rd[2] == 1'b0) break;
            n++;
        end
        check("sim_idle_seen", rd, 32'h30 | PBIT);
        bus.addr  = A_TX;
        bus.wdata = 32'h55;
        bus.we    = 1'b1;
        @(posedge clock);
        #1;
        bus.we = 1'b0;
        bus_read(A_ST, rd);
        check("sim_post", rd, 32'h34 | PBIT);
        wait_idle("sim_idle", 300);
        check_rx("sim_rx");

        // Reset asserted during data bit 3 of 0x00 with 0x11 still queued.
        rx_en = 1'b0;
        bus_write(A_DIV, 32'h4);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h11);
        for (int k = 1; k <= 18; k++) @(negedge clock);
        check("midrst_bit3", 32'(txd), 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_txd", 32'(txd), 32'h1);
        check("midrst_irq", 32'(irq), 32'h1);
        bus_read(A_ST, rd);
        check("midrst_status", rd, ST_EMPTY);
        @(negedge clock);
        reset = 1'b1;
        bus_read(A_DIV, rd);
        check("midrst_div", rd, 32'h1B2);
        bus_write(A_DIV, 32'h4);
        rx_div = 4;
        rx_q.delete();
        exp_q = '{8'h3C};
        rx_en = 1'b1;
        bus_write(A_TX, 32'h3C);
        wait_idle("midrst_idle", 100);
        check_rx("midrst_rx");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sccpu_uart_tx.md
# sccpu_uart_tx

Memory-mapped UART transmitter on the single-cycle CPU's data-memory port, downstream of the datapath. It decodes the CPU's ALU address, store-data and write-enable outputs. It claims a small address window and drives read data back onto the data-memory return path. Stored bytes are queued in a FIFO and serialised 8N1 on `txd` at a programmable baud divisor.

## Interface
Parameters:
- `BASE`, 32'h0000_FF00: window base address; window covers `BASE`..`BASE+32'hB`.
- `DEPTH_LOG2`, 3: FIFO depth is 2**DEPTH_LOG2 entries (8).
- `DIV_RESET`, 16'd434: divisor value after reset.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately.
- `addr` in 32: byte address (CPU ALU result).
- `wdata` in 32: store data (CPU register-file port B).
- `we` in 1: store strobe (CPU data-memory write enable).
- `sel` out 1: combinational; 1 when `addr[31:4]==BASE[31:4]` and `addr[3:2]!=2'b11`.
- `rdata` out 32: combinational read data; 0 when `sel`=0.
- `txd` out 1: serial output; idle high.
- `irq` out 1: registered; 1 while the FIFO is empty and the transmitter is idle.

## Operation
Register map, word offsets with `addr[1:0]` ignored:
- 0x0 TXDATA. Write pushes `wdata[7:0]`. Read returns 0.
- 0x4 STATUS, read-only except bit 3.
  - bit0 full.
  - bit1 empty.
  - bit2 busy: FSM not IDLE.
  - bit3 ovf: sticky. Writing 1 to bit3 clears it; writing 0 has no effect.
  - bits[7:4] count: 0..DEPTH.
  - Other bits read 0.
- 0x8 DIV. Write stores `wdata[15:0]`; a written value of 0 is stored as 1. Read returns `{16'b0, div}`.

A write is accepted when `we & sel` is 1 at a rising edge.

FIFO:
- Circular buffer with `DEPTH_LOG2`-bit read and write pointers that wrap modulo DEPTH, plus a count of `DEPTH_LOG2+1` bits.
- Full is `count==DEPTH`, taken from the registered count at the start of the cycle.
- A push while full is dropped and sets ovf. This holds even if a pop occurs in the same cycle.
- A push and a pop in the same cycle (not full, not empty): count is unchanged and both pointers advance.
- A pop only occurs when the FIFO is non-empty at the start of the cycle. A byte pushed into an empty FIFO is popped no earlier than the next cycle.

TX FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter, go to START.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA: `txd`=shift[0], LSB first. At each bit-period end, shift right and increment the bit index. After bit 7, go to PARITY (macro defined) or STOP.
- STOP: `txd`=1 for one bit period, then go to IDLE.
- Back-to-back bytes: IDLE lasts exactly one cycle before the next START.

Bit period:
- Baud counter is 16 bits. It reloads to `div-1` on entering a state and decrements each cycle.
- The period ends when the counter is 0, so each bit lasts `div` clocks.
- A DIV write takes effect at the next reload; the current bit is not disturbed.

## Timing
- Reset values: `txd`=1, `irq`=1, FSM=IDLE, count=0, pointers=0, ovf=0, div=`DIV_RESET`, baud counter=0.
- `rdata` and `sel` are combinational from `addr` and current state, so a load in the CPU's single cycle sees state before that cycle's edge.
- Push to first start bit: the byte is written at edge N, popped at edge N+1, and `txd` falls after edge N+1.
- Frame length: 10·div clocks (11·div with parity), plus one IDLE cycle between frames.
- `irq` changes one cycle after the condition changes.
- Reset asserted mid-frame: `txd` returns to 1 asynchronously and the queued data is lost.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted after DATA, driving the even parity bit `^byte` for one bit period.
  - STATUS bit8 reads 1.
- Not defined: no PARITY state, frame is 8N1, STATUS bit8 reads 0.

## Test plan
- Reset check: hold `reset`=0 → `txd`=1, `irq`=1, STATUS=0x0000_0002, DIV=434. Release `reset`, then read DIV → 0x0000_01B2.
- Single frame: write DIV=4, then TXDATA=0x55 → `txd` shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 clocks, with the first falling edge one cycle after the push. `irq` is 0 during the frame and 1 afterwards.
- Queue and wrap: write 8 bytes 0x00–0x07 → STATUS count=8, full=1. Write 0x08 → dropped, ovf=1. Write STATUS=0x8 → ovf=0. Push 4 more after 4 pops → pointers wrap and bytes emerge in order.
- Simultaneous push and pop: push a byte in the exact cycle IDLE pops with count=3 → count stays 3 and the byte order is preserved.
- Divisor edge cases:
  - write DIV=0 → reads 1, bit period is 1 clock;
  - change DIV from 4 to 8 mid-DATA → the current bit keeps 4 clocks, the following bits take 8.
- Reset mid-frame: assert `reset` during DATA bit 3 → `txd`=1 immediately, count=0. After release, the next push transmits normally.
